rv32i_pc_ctrl: RTL and testbench
================================

RV32I_PC_CTRL -- requirements
Module: rv32i_pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_stall  in  1  hazard stall; blocks issue of new fetches.
REQ-006 i_br_taken  in  1  EX-stage branch/JALR redirect strobe.
REQ-007 i_br_target  in  WIDTH  EX-stage redirect target.
REQ-008 i_jal_valid  in  1  ID-stage JAL redirect strobe.
REQ-009 i_jal_target  in  WIDTH  ID-stage redirect target.
REQ-010 o_imem_req  out  1  instruction-memory request.
REQ-011 o_imem_addr  out  WIDTH  request address, word aligned.
REQ-012 i_imem_gnt  in  1  request accepted this cycle.
REQ-013 i_imem_rvalid  in  1  response valid; never earlier than the cycle after gnt.
REQ-014 i_imem_rdata  in  32  response instruction word.
REQ-015 o_if_valid  out  1  IF/ID output holds a valid instruction.
REQ-016 o_if_pc  out  WIDTH  PC of the output instruction.
REQ-017 o_if_instr  out  32  output instruction word.
REQ-018 i_if_ready  in  1  ID consumes output when o_if_valid & i_if_ready.
REQ-019 o_flush  out  1  combinational; high in any cycle a redirect is accepted.

Function
REQ-020 FSM states: BOOT, REQ, WAIT_RSP, DRAIN.
REQ-021 BOOT lasts exactly one cycle after reset release and moves to REQ; no request is issued in BOOT.
REQ-022 REQ: o_imem_req=1 only when !i_stall and (output buffer empty or being consumed this cycle); o_imem_addr = fetch_pc.
REQ-023 REQ with gnt: issued_pc <= fetch_pc; fetch_pc <= fetch_pc+4 modulo 2^WIDTH; move to WAIT_RSP.
REQ-024 At most one request outstanding; o_imem_req=0 outside REQ.
REQ-025 WAIT_RSP with rvalid: buffer <= {issued_pc, rdata}; o_if_valid <= 1; move to REQ.
REQ-026 Buffer holds contents stable while o_if_valid & !i_if_ready; it clears on consume unless refilled in the same cycle.
REQ-027 Redirect priority: i_br_taken over i_jal_valid over sequential; a redirect is accepted in any non-BOOT state.
REQ-028 On redirect: fetch_pc <= target with bits [1:0] forced to 0; o_if_valid <= 0; o_flush=1 in the same cycle.
REQ-029 Redirect while a request is outstanding (WAIT_RSP, or REQ with gnt that cycle): move to DRAIN.
REQ-030 DRAIN: o_imem_req=0; the next rvalid is discarded without touching the buffer, then move to REQ.
REQ-031 Redirect in DRAIN: update fetch_pc only and remain in DRAIN.
REQ-032 Redirect and rvalid in the same cycle in WAIT_RSP: discard the response and move to REQ (not DRAIN).
REQ-033 i_stall does not block redirects or the acceptance of responses.

Reset
REQ-034 On rst: state=BOOT, fetch_pc=RESET_PC, issued_pc=0, o_if_valid=0, o_if_pc=0, o_if_instr=32'h0000_0013 (NOP), o_imem_req=0.
REQ-035 rst asserted mid-transaction abandons the outstanding request; a response arriving after reset release, before the first new gnt, is ignored.

Structure
REQ-036 The state enum, RESET_PC default, and NOP constant SHALL live in the shared package rv32i_pkg.
REQ-037 Redirect priority selection SHALL be a sub-module, rv32i_redirect_mux (combinational, outputs redirect valid and target).
REQ-038 The block SHALL drive the existing PC register only through its redirect outputs; it keeps its own fetch_pc and creates no second PC source.

Verification
REQ-039 Reset release, gnt and rvalid always 1, ready=1 -> addresses 0x0, 0x4, 0x8 with one request per two cycles; o_if_pc matches each address.
REQ-040 i_if_ready=0 for 5 cycles with the buffer full -> no new request is issued; o_if_pc and o_if_instr are unchanged.
REQ-041 i_br_taken=1, target 0x103, during WAIT_RSP -> o_flush for 1 cycle; the pending rdata is dropped; next request address is 0x100.
REQ-042 i_br_taken (target 0x200) and i_jal_valid (target 0x300) in the same cycle -> next request address is 0x200.
REQ-043 fetch_pc=0xFFFF_FFFC, granted -> next request address is 0x0000_0000.
REQ-044 rst pulse during WAIT_RSP, then a stray rvalid -> o_if_valid stays 0; the first request after BOOT is to RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch-side PC controller.
package rv32i_pkg;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DRAIN    = 2'd3
   } pc_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/rv32i_pc_ctrl_if.sv
// Instruction-memory request/response bus between the PC controller and imem.
interface rv32i_pc_ctrl_if #(
   parameter int WIDTH = 32
) ();

   logic             o_imem_req;
   logic [WIDTH-1:0] o_imem_addr;
   logic             i_imem_gnt;
   logic             i_imem_rvalid;
   logic [31:0]      i_imem_rdata;

   modport master (
      output o_imem_req,
      output o_imem_addr,
      input  i_imem_gnt,
      input  i_imem_rvalid,
      input  i_imem_rdata
   );

   modport slave (
      input  o_imem_req,
      input  o_imem_addr,
      output i_imem_gnt,
      output i_imem_rvalid,
      output i_imem_rdata
   );

endinterface

// File: rtl/rv32i_redirect_mux.sv
// Redirect priority select: EX branch/JALR beats ID JAL. Target is word aligned.
module rv32i_redirect_mux #(
   parameter int WIDTH = 32
) (
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jal_valid,
   input  logic [WIDTH-1:0] jal_target,
   output logic             redir_valid,
   output logic [WIDTH-1:0] redir_target
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

   // pick the highest-priority redirect source and clear the byte offset
   always_comb begin
      redir_valid  = br_taken | jal_valid;
      redir_target = jal_target & ALIGN_MASK;
      if (br_taken) begin
         redir_target = br_target & ALIGN_MASK;
      end
   end

endmodule

// File: rtl/rv32i_pc_ctrl.sv
// Fetch PC controller: issues one imem request at a time, buffers the response
// into a single IF/ID slot and handles branch/JAL redirects.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// BOOT     | one idle cycle after reset release, no request
// REQ      | may issue a request for fetch_pc
// WAIT_RSP | request granted, waiting for its response
// DRAIN    | redirected with a request in flight; next response is dropped
module rv32i_pc_ctrl
   import rv32i_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_stall,
   input  logic             i_br_taken,
   input  logic [WIDTH-1:0] i_br_target,
   input  logic             i_jal_valid,
   input  logic [WIDTH-1:0] i_jal_target,
   rv32i_pc_ctrl_if.master  imem,
   output logic             o_if_valid,
   output logic [WIDTH-1:0] o_if_pc,
   output logic [31:0]      o_if_instr,
   input  logic             i_if_ready,
   output logic             o_flush
);

   pc_state_e        state;
   pc_state_e        state_nxt;
   logic [WIDTH-1:0] fetch_pc;
   logic [WIDTH-1:0] issued_pc;
   logic             redir_valid;
   logic [WIDTH-1:0] redir_target;
   logic             redir_acc;
   logic             buf_free;
   logic             req;
   logic             fire;
   logic             rsp_capture;

   rv32i_redirect_mux #(.WIDTH(WIDTH)) u_redirect_mux (
      .br_taken     (i_br_taken),
      .br_target    (i_br_target),
      .jal_valid    (i_jal_valid),
      .jal_target   (i_jal_target),
      .redir_valid  (redir_valid),
      .redir_target (redir_target)
   );

   // handshake qualifiers; a response is only kept when no redirect kills it
   always_comb begin
      buf_free    = !o_if_valid || i_if_ready;
      redir_acc   = redir_valid && (state != ST_BOOT);
      req         = (state == ST_REQ) && !i_stall && buf_free;
      fire        = req && imem.i_imem_gnt;
      rsp_capture = (state == ST_WAIT_RSP) && imem.i_imem_rvalid && !redir_acc;
   end

   assign imem.o_imem_req  = req;
   assign imem.o_imem_addr = fetch_pc;
   assign o_flush          = redir_acc;

   // next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_BOOT: state_nxt = ST_REQ;
         ST_REQ: begin
            if (fire) begin
               state_nxt = redir_acc ? ST_DRAIN : ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            // a redirect coinciding with the response drops it right here,
            // so there is nothing left to drain
            if (imem.i_imem_rvalid) begin
               state_nxt = ST_REQ;
            end else if (redir_acc) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (imem.i_imem_rvalid) begin
               state_nxt = ST_REQ;
            end
         end
         default: state_nxt = ST_BOOT;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // fetch and issued PC; a redirect overrides the sequential increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         issued_pc <= '0;
      end else begin
         if (fire) begin
            issued_pc <= fetch_pc;
         end
         if (redir_acc) begin
            fetch_pc <= redir_target;
         end else if (fire) begin
            fetch_pc <= fetch_pc + WIDTH'(4);
         end
      end
   end

   // IF/ID output slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_if_valid <= 1'b0;
         o_if_pc    <= '0;
         o_if_instr <= INSTR_NOP;
      end else begin
         if (redir_acc) begin
            o_if_valid <= 1'b0;
         end else if (rsp_capture) begin
            o_if_valid <= 1'b1;
            o_if_pc    <= issued_pc;
            o_if_instr <= imem.i_imem_rdata;
         end else if (o_if_valid && i_if_ready) begin
            o_if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rv32i_pc_ctrl.sv
// Self-checking bench for rv32i_pc_ctrl: reference PC model plus a queue of
// expected IF/ID words, a redirect vector table and corner-case sequences.
module tb_rv32i_pc_ctrl;
   import rv32i_pkg::*;

   localparam logic [31:0] RST_PC = RESET_PC_DEFAULT;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_stall;
   logic        i_br_taken;
   logic [31:0] i_br_target;
   logic        i_jal_valid;
   logic [31:0] i_jal_target;
   logic        o_if_valid;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_instr;
   logic        i_if_ready;
   logic        o_flush;

   always #5 clk = ~clk;

   rv32i_pc_ctrl_if #(.WIDTH(32)) bus ();

   rv32i_pc_ctrl #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_stall      (i_stall),
      .i_br_taken   (i_br_taken),
      .i_br_target  (i_br_target),
      .i_jal_valid  (i_jal_valid),
      .i_jal_target (i_jal_target),
      .imem         (bus),
      .o_if_valid   (o_if_valid),
      .o_if_pc      (o_if_pc),
      .o_if_instr   (o_if_instr),
      .i_if_ready   (i_if_ready),
      .o_flush      (o_flush)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic        br;
      logic [31:0] br_t;
      logic        jal;
      logic [31:0] jal_t;
      logic [31:0] exp_addr;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   vec_t        vecs[7];
   logic [31:0] model_pc;
   logic [31:0] last_gnt_addr;
   logic        granted;
   int          n_gnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one clock cycle: inputs are already driven at posedge+1
   task automatic cyc();
      logic        redir;
      logic [31:0] tgt;
      exp_t        e;
      #1;
      redir = i_br_taken || i_jal_valid;
      tgt   = i_br_taken ? i_br_target : i_jal_target;
      check("flush", o_flush, redir);
      granted = bus.o_imem_req && bus.i_imem_gnt;
      if (o_if_valid && i_if_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", o_if_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("if_pc", o_if_pc, e.pc);
            check("if_instr", o_if_instr, e.instr);
         end
      end
      if (granted) begin
         check("req_addr", bus.o_imem_addr, model_pc);
         last_gnt_addr = bus.o_imem_addr;
         n_gnt++;
      end
      if (redir) begin
         exp_q.delete();
         model_pc = tgt & ~32'h3;
      end else if (granted) begin
         exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
         model_pc = model_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      bus.i_imem_rdata = mem_word(last_gnt_addr);
   endtask

   task automatic wait_grant(input string name, input int budget);
      granted = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (granted) break;
      end
      checks++;
      if (!granted) begin
         errors++;
         $display("FAIL %s: got no grant, expected one within %0d cycles", name, budget);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      model_pc = RST_PC;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", o_if_valid, 1'b0);
      check("rst_pc", o_if_pc, 32'h0);
      check("rst_instr", o_if_instr, INSTR_NOP);
      rst = 1'b0;
      check("boot_req", bus.o_imem_req, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{br: 1'b1, br_t: 32'h0000_0103, jal: 1'b0, jal_t: 32'h0,          exp_addr: 32'h0000_0100};
      vecs[1] = '{br: 1'b0, br_t: 32'h0,          jal: 1'b0, jal_t: 32'h0,          exp_addr: 32'h0000_0104};
      vecs[2] = '{br: 1'b1, br_t: 32'h0000_0200, jal: 1'b1, jal_t: 32'h0000_0300, exp_addr: 32'h0000_0200};
      vecs[3] = '{br: 1'b0, br_t: 32'h0000_0700, jal: 1'b1, jal_t: 32'h0000_0302, exp_addr: 32'h0000_0300};
      vecs[4] = '{br: 1'b1, br_t: 32'hFFFF_FFFE, jal: 1'b0, jal_t: 32'h0,          exp_addr: 32'hFFFF_FFFC};
      vecs[5] = '{br: 1'b0, br_t: 32'h0,          jal: 1'b0, jal_t: 32'h0,          exp_addr: 32'h0000_0000};
      vecs[6] = '{br: 1'b0, br_t: 32'h0,          jal: 1'b0, jal_t: 32'h0,          exp_addr: 32'h0000_0004};

      rst = 1'b1;
      i_stall = 1'b0;
      i_br_taken = 1'b0;
      i_br_target = '0;
      i_jal_valid = 1'b0;
      i_jal_target = '0;
      i_if_ready = 1'b1;
      bus.i_imem_gnt = 1'b1;
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata = '0;
      model_pc = RST_PC;
      last_gnt_addr = '0;
      n_gnt = 0;
      granted = 1'b0;

      // streaming with gnt/rvalid/ready tied high: 0x0, 0x4, 0x8
      do_reset();
      repeat (6) cyc();
      check("stream_gnt_count", n_gnt, 32'd3);

      // back-pressure: buffer holds 0x8 while ID is not ready
      i_if_ready = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         check("bp_req", bus.o_imem_req, 1'b0);
         check("bp_valid", o_if_valid, 1'b1);
         check("bp_pc", o_if_pc, 32'h8);
         check("bp_instr", o_if_instr, mem_word(32'h8));
         cyc();
      end

      // hazard stall blocks issue but not consumption
      i_stall = 1'b1;
      i_if_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("stall_req", bus.o_imem_req, 1'b0);
         cyc();
      end
      i_stall = 1'b0;
      bus.i_imem_rvalid = 1'b0;
      wait_grant("stall_release_grant", 4);

      // redirect vectors, each applied in WAIT_RSP
      for (int v = 0; v < 7; v++) begin
         i_br_taken   = vecs[v].br;
         i_br_target  = vecs[v].br_t;
         i_jal_valid  = vecs[v].jal;
         i_jal_target = vecs[v].jal_t;
         if (!vecs[v].br && !vecs[v].jal) bus.i_imem_rvalid = 1'b1;
         cyc();
         i_br_taken  = 1'b0;
         i_jal_valid = 1'b0;
         if (vecs[v].br || vecs[v].jal) begin
            check($sformatf("vec%0d_drain_req", v), bus.o_imem_req, 1'b0);
            bus.i_imem_rvalid = 1'b1;
            cyc();
         end
         bus.i_imem_rvalid = 1'b0;
         wait_grant($sformatf("vec%0d_grant", v), 4);
         check($sformatf("vec%0d_addr", v), last_gnt_addr, vecs[v].exp_addr);
      end

      // redirect and response together in WAIT_RSP: straight back to REQ
      i_br_taken = 1'b1;
      i_br_target = 32'h0000_0400;
      bus.i_imem_rvalid = 1'b1;
      cyc();
      i_br_taken = 1'b0;
      bus.i_imem_rvalid = 1'b0;
      check("same_cycle_valid", o_if_valid, 1'b0);
      wait_grant("same_cycle_grant", 1);
      check("same_cycle_addr", last_gnt_addr, 32'h0000_0400);

      // redirect while granting in REQ, then a second redirect inside DRAIN
      bus.i_imem_rvalid = 1'b1;
      cyc();
      bus.i_imem_rvalid = 1'b0;
      check("rg_req", bus.o_imem_req, 1'b1);
      i_jal_valid = 1'b1;
      i_jal_target = 32'h0000_0500;
      cyc();
      i_jal_valid = 1'b0;
      check("drain_req0", bus.o_imem_req, 1'b0);
      cyc();
      i_br_taken = 1'b1;
      i_br_target = 32'h0000_0601;
      cyc();
      i_br_taken = 1'b0;
      check("drain_req1", bus.o_imem_req, 1'b0);
      bus.i_imem_rvalid = 1'b1;
      cyc();
      bus.i_imem_rvalid = 1'b0;
      check("drain_valid", o_if_valid, 1'b0);
      wait_grant("drain_exit_grant", 2);
      check("drain_exit_addr", last_gnt_addr, 32'h0000_0600);

      // reset in WAIT_RSP, then a stray response before the first new grant
      bus.i_imem_gnt = 1'b0;
      do_reset();
      bus.i_imem_rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("stray_valid", o_if_valid, 1'b0);
         check("stray_req", bus.o_imem_req, 1'b1);
      end
      bus.i_imem_gnt = 1'b1;
      bus.i_imem_rvalid = 1'b0;
      wait_grant("post_reset_grant", 2);
      check("post_reset_addr", last_gnt_addr, RST_PC);
      bus.i_imem_rvalid = 1'b1;
      cyc();
      bus.i_imem_rvalid = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
